encoder_layer_0_intermediate_dense_bias_add: RTL

Streaming bias-add stage directly downstream of the intermediate-dense bias source. Joins the matmul result stream with the bias stream beat-for-beat, aligns both fixed-point formats, adds, rounds and saturates into the output format. Output is a 2-deep pipeline behind a skid buffer, giving full throughput with no combinational ready path. Feeds the activation stage.

---
 rtl/bias_add_pkg.sv | 57 +++++
 rtl/bias_add_skid_buffer.sv | 55 +++++
 rtl/encoder_layer_0_intermediate_dense_bias_add.sv | 119 +++++++++++
 3 files changed

// File: rtl/bias_add_pkg.sv
// Shared format arithmetic for the encoder bias-add stage:
// aligned-sum sizing, round shift, round-half-up and saturation helpers.
package bias_add_pkg;

    localparam int MAXW = 64;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int frac_sum(input int fd, input int fb);
        return max2(fd, fb);
    endfunction

    function automatic int sum_width(input int wd, input int fd,
                                     input int wb, input int fb);
        return max2(wd - fd, wb - fb) + max2(fd, fb) + 1;
    endfunction

    function automatic int round_shift(input int fd, input int fb,
                                       input int fo);
        return max2(fd, fb) - fo;
    endfunction

    function automatic logic signed [MAXW-1:0] round_half_up(
        input logic signed [MAXW-1:0] x, input int sh);
        logic signed [MAXW-1:0] half;
        if (sh <= 0) return x;
        half = MAXW'(1) <<< (sh - 1);
        return (x + half) >>> sh;
    endfunction

    function automatic logic signed [MAXW-1:0] sat_hi(input int w);
        return (MAXW'(1) <<< (w - 1)) - MAXW'(1);
    endfunction

    function automatic logic signed [MAXW-1:0] sat_lo(input int w);
        return -(MAXW'(1) <<< (w - 1));
    endfunction

    function automatic logic signed [MAXW-1:0] round_sat(
        input logic signed [MAXW-1:0] x, input int sh, input int w);
        logic signed [MAXW-1:0] r;
        r = round_half_up(x, sh);
        if (r > sat_hi(w)) return sat_hi(w);
        if (r < sat_lo(w)) return sat_lo(w);
        return r;
    endfunction

    function automatic logic sat_hit(
        input logic signed [MAXW-1:0] x, input int sh, input int w);
        logic signed [MAXW-1:0] r;
        r = round_half_up(x, sh);
        return (r > sat_hi(w)) || (r < sat_lo(w));
    endfunction

endpackage

// File: rtl/bias_add_skid_buffer.sv
// Two-entry output skid buffer; in_ready comes straight from a flop
// so downstream ready never reaches the upstream ready path.
module bias_add_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] e0, e1;
    logic [1:0]       cnt, cnt_nxt;
    logic             rdy_q, push, pop;

    assign in_ready  = rdy_q;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = e0;
    assign push      = in_valid && rdy_q;
    assign pop       = out_valid && out_ready;
    assign cnt_nxt   = cnt + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            rdy_q <= 1'b1;
            e0    <= '0;
            e1    <= '0;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt != 2'd2);
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= in_data;
                    else             e1 <= in_data;
                end
                2'b01: e0 <= e1;
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= in_data;
                    end else begin
                        e0 <= e1;
                        e1 <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/encoder_layer_0_intermediate_dense_bias_add.sv
// Joins matmul and bias streams, aligns, adds, rounds and saturates.
// Define BIAS_ADD_SAT_FLAG_EN to add the sticky sat_flag output.
module encoder_layer_0_intermediate_dense_bias_add
    import bias_add_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int BIAS_PRECISION_0       = 16,
    parameter int BIAS_PRECISION_1       = 3,
    parameter int DATA_OUT_0_PRECISION_0 = 16,
    parameter int DATA_OUT_0_PRECISION_1 = 3,
    parameter int PARALLELISM            = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    input  logic [BIAS_PRECISION_0-1:0]       bias [PARALLELISM],
    input  logic                              bias_valid,
    output logic                              bias_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [PARALLELISM],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
`ifdef BIAS_ADD_SAT_FLAG_EN
    ,
    output logic                              sat_flag
`endif
);

    localparam int F_S = frac_sum(DATA_IN_0_PRECISION_1, BIAS_PRECISION_1);
    localparam int W_S = sum_width(DATA_IN_0_PRECISION_0,
                                   DATA_IN_0_PRECISION_1,
                                   BIAS_PRECISION_0, BIAS_PRECISION_1);
    localparam int SH  = round_shift(DATA_IN_0_PRECISION_1,
                                     BIAS_PRECISION_1,
                                     DATA_OUT_0_PRECISION_1);
    localparam int SHD = F_S - DATA_IN_0_PRECISION_1;
    localparam int SHB = F_S - BIAS_PRECISION_1;
    localparam int W_O = DATA_OUT_0_PRECISION_0;
    localparam int VW  = W_O * PARALLELISM;

    logic                  s1_v, s1_accept, join_fire;
    logic                  sb_ready, sb_push, sb_valid;
    logic signed [W_S-1:0] sum    [PARALLELISM];
    logic signed [W_S-1:0] s1_sum [PARALLELISM];
    logic [VW-1:0]         sb_in, sb_out;

    assign s1_accept       = !s1_v || sb_ready;
    assign join_fire       = data_in_0_valid && bias_valid && s1_accept;
    assign data_in_0_ready = bias_valid && s1_accept;
    assign bias_ready      = data_in_0_valid && s1_accept;
    assign sb_push         = s1_v && sb_ready;

    // Both operands brought to F_S fraction bits; W_S leaves room for carry.
    always_comb begin
        for (int i = 0; i < PARALLELISM; i++) begin
            sum[i] = (W_S'($signed(data_in_0[i])) <<< SHD)
                   + (W_S'($signed(bias[i])) <<< SHB);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            for (int i = 0; i < PARALLELISM; i++) s1_sum[i] <= '0;
        end else if (s1_accept) begin
            s1_v <= join_fire;
            if (join_fire) begin
                for (int i = 0; i < PARALLELISM; i++) s1_sum[i] <= sum[i];
            end
        end
    end

    always_comb begin
        sb_in = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            sb_in[i*W_O +: W_O] = W_O'(round_sat(MAXW'(s1_sum[i]), SH, W_O));
        end
    end

    bias_add_skid_buffer #(
        .WIDTH(VW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (sb_in),
        .in_valid (s1_v),
        .in_ready (sb_ready),
        .out_data (sb_out),
        .out_valid(sb_valid),
        .out_ready(data_out_0_ready)
    );

    assign data_out_0_valid = sb_valid;

    always_comb begin
        for (int i = 0; i < PARALLELISM; i++) begin
            data_out_0[i] = sb_out[i*W_O +: W_O];
        end
    end

`ifdef BIAS_ADD_SAT_FLAG_EN
    logic [PARALLELISM-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            hit[i] = sat_hit(MAXW'(s1_sum[i]), SH, W_O);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                  sat_flag <= 1'b0;
        else if (sb_push && |hit) sat_flag <= 1'b1;
    end
`endif

endmodule
